// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between the CPU control path and the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start_i;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic [3:0]       ctrl_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;
   logic             cout_o;
   logic             overflow_o;

   modport master (
      output start_i, src1_i, src2_i, ctrl_i,
      input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
   );

   modport slave (
      input  start_i, src1_i, src2_i, ctrl_i,
      output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
   );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit slice driven LSB-first, carry flop between bits.
// Optional macro ALU_SERIAL_OVF_EN builds the MSB carry-in register and signed overflow flag.
module alu_serial_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   alu_serial_ctrl_if.slave bus
);
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SLT = 2'b11;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, sh_q, sh_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d, set_q, set_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
`ifdef ALU_SERIAL_OVF_EN
   logic             cin_msb_q, cin_msb_d;
`endif

   logic             a_c, b_c, sum_c, cnext_c, bit_c;
   logic [WIDTH-1:0] res_c;

   // Slice, sequencing and output update
   always_comb begin
      state_d  = state_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      sh_d     = sh_q;
      ctrl_d   = ctrl_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      set_d    = set_q;
      result_d = result_q;
      zero_d   = zero_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
`ifdef ALU_SERIAL_OVF_EN
      cin_msb_d = cin_msb_q;
`endif

      a_c     = op1_q[0] ^ ctrl_q[3];
      b_c     = op2_q[0] ^ ctrl_q[2];
      sum_c   = a_c ^ b_c ^ carry_q;
      cnext_c = (a_c & b_c) | ((a_c | b_c) & carry_q);
      unique case (ctrl_q[1:0])
         OP_AND:  bit_c = a_c & b_c;
         OP_OR:   bit_c = a_c | b_c;
         OP_ADD:  bit_c = sum_c;
         default: bit_c = 1'b0;
      endcase

      res_c = sh_q;
      if (ctrl_q[1:0] == OP_SLT) res_c[0] = set_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               op1_d   = bus.src1_i;
               op2_d   = bus.src2_i;
               ctrl_d  = bus.ctrl_i;
               carry_d = bus.ctrl_i[2];
               cnt_d   = '0;
               sh_d    = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Operands shift right so the active bit is always at index 0
            op1_d   = op1_q >> 1;
            op2_d   = op2_q >> 1;
            sh_d    = {bit_c, sh_q[WIDTH-1:1]};
            carry_d = cnext_c;
            if (cnt_q == LAST_IDX) begin
               set_d   = sum_c;
`ifdef ALU_SERIAL_OVF_EN
               cin_msb_d = carry_q;
`endif
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FIN: begin
            result_d = res_c;
            zero_d   = (res_c == '0);
            cout_d   = carry_q;
`ifdef ALU_SERIAL_OVF_EN
            ovf_d    = ctrl_q[1] & (cin_msb_q ^ carry_q);
`else
            ovf_d    = 1'b0;
`endif
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_q == FIN);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         op1_q    <= '0;
         op2_q    <= '0;
         sh_q     <= '0;
         ctrl_q   <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         set_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
         cin_msb_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         sh_q     <= sh_d;
         ctrl_q   <= ctrl_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         set_q    <= set_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
`ifdef ALU_SERIAL_OVF_EN
         cin_msb_q <= cin_msb_d;
`endif
      end
   end

   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.result_o   = result_q;
   assign bus.zero_o     = zero_q;
   assign bus.cout_o     = cout_q;
   assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl (WIDTH=32).
module tb_alu_serial_ctrl;
   localparam int unsigned W = 32;
   localparam int LAT = W + 1;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   lat;

   alu_serial_ctrl_if #(.WIDTH(W)) bus ();

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait for done_o; returns edges since accept (-1 on timeout)
   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= LAT + 8; i++) begin
         tick();
         if (bus.done_o === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int n);
      bus.ctrl_i  = c;
      bus.src1_i  = a;
      bus.src2_i  = b;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      wait_done(n);
   endtask

   task automatic chk_out(input string tag, input logic [W-1:0] res, input logic z,
                          input logic co, input logic ov);
      chk({tag, ".result"}, bus.result_o, res);
      chk({tag, ".zero"}, W'(bus.zero_o), W'(z));
      chk({tag, ".cout"}, W'(bus.cout_o), W'(co));
      chk({tag, ".ovf"}, W'(bus.overflow_o), W'(ov));
   endtask

   initial begin
      logic ovf_exp;
`ifdef ALU_SERIAL_OVF_EN
      ovf_exp = 1'b1;
`else
      ovf_exp = 1'b0;
`endif
      bus.start_i = 1'b0;
      bus.src1_i  = '0;
      bus.src2_i  = '0;
      bus.ctrl_i  = '0;
      tick();
      tick();
      chk("rst.busy", W'(bus.busy_o), '0);
      chk("rst.done", W'(bus.done_o), '0);
      chk_out("rst", '0, 1'b0, 1'b0, 1'b0);
      rst_i = 1'b1;
      tick();

      // ADD 0xFF + 1
      run_op(4'b0010, 32'h0000_00FF, 32'h0000_0001, lat);
      chk("add.latency", W'(lat), W'(LAT));
      chk("add.busy_in_done", W'(bus.busy_o), '0);
      chk_out("add", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
      tick();
      chk("add.done_pulse", W'(bus.done_o), '0);

      // Reset while RUN is at bit 10
      bus.ctrl_i = 4'b0010; bus.src1_i = 32'd5; bus.src2_i = 32'd3; bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("midrst.busy_before", W'(bus.busy_o), W'(1));
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      chk("midrst.busy", W'(bus.busy_o), '0);
      chk("midrst.result", bus.result_o, '0);
      tick();
      tick();
      chk("midrst.no_done", W'(bus.done_o), '0);
      run_op(4'b0010, 32'd5, 32'd3, lat);
      chk("midrst.latency", W'(lat), W'(LAT));
      chk_out("midrst", 32'd8, 1'b0, 1'b0, 1'b0);
      tick();

      // SUB equal operands
      run_op(4'b0110, 32'h1234_5678, 32'h1234_5678, lat);
      chk("sub.latency", W'(lat), W'(LAT));
      chk_out("sub", '0, 1'b1, 1'b1, 1'b0);
      tick();

      // Signed SLT both orders
      run_op(4'b0111, 32'hFFFF_FFFE, 32'h0000_0003, lat);
      chk("slt1.latency", W'(lat), W'(LAT));
      chk_out("slt1", 32'h0000_0001, 1'b0, 1'b1, 1'b0);
      tick();
      run_op(4'b0111, 32'h0000_0003, 32'hFFFF_FFFE, lat);
      chk_out("slt2", '0, 1'b1, 1'b0, 1'b0);
      tick();

      // Signed overflow on ADD
      run_op(4'b0010, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat);
      chk_out("ovf", 32'hFFFF_FFFE, 1'b0, 1'b0, ovf_exp);
      tick();

      // NOR with start pulses during RUN that must be ignored
      bus.ctrl_i = 4'b1100; bus.src1_i = 32'hF0F0_0000; bus.src2_i = 32'h0F0F_0000;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      bus.ctrl_i = 4'b0010; bus.src1_i = 32'h1111_1111; bus.src2_i = 32'h2222_2222;
      for (int i = 0; i < 5; i++) begin
         tick();
         bus.start_i = ~bus.start_i;
      end
      bus.start_i = 1'b0;
      wait_done(lat);
      chk("nor.latency", W'(lat), W'(LAT - 5));
      chk_out("nor", 32'h0000_FFFF, 1'b0, 1'b1, 1'b0);
      tick();
      chk("nor.no_restart", W'(bus.busy_o), '0);

      // start_i held high: second op accepted on the edge ending the done cycle
      bus.ctrl_i = 4'b0001; bus.src1_i = 32'h0000_00F0; bus.src2_i = 32'h0000_000F;
      bus.start_i = 1'b1;
      tick();
      bus.ctrl_i = 4'b0010; bus.src1_i = 32'd100; bus.src2_i = 32'd23;
      wait_done(lat);
      chk("held.latency1", W'(lat), W'(LAT));
      chk_out("held1", 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
      tick();
      bus.start_i = 1'b0;
      chk("held.accept_busy", W'(bus.busy_o), W'(1));
      chk("held.accept_done", W'(bus.done_o), '0);
      chk("held.result_stable", bus.result_o, 32'h0000_00FF);
      wait_done(lat);
      chk("held.latency2", W'(lat), W'(LAT));
      chk_out("held2", 32'd123, 1'b0, 1'b0, 1'b0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
